// File: rtl/sm3_stream_hash_pkg.sv
// sm3_stream_hash_pkg: shared SM3 constants, engine state encoding and word helpers
// Contents: SM3_IV, SM3_BLK_W, SM3_HASH_W, state_t, rotl/p0/p1 used by the compression core.
package sm3_stream_hash_pkg;
  localparam int SM3_BLK_W = 512;
  localparam int SM3_HASH_W = 256;
  localparam logic [SM3_HASH_W-1:0] SM3_IV =
    256'h7380166f4914b2b9172442d7da8a0600a96f30bc163138aae38dee4db0fb0e4e;
  typedef enum logic [1:0] {IDLE, WAIT_BLK, COMPRESS, FINISH} state_t;
  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction
  function automatic logic [31:0] p0(input logic [31:0] x);
    return x ^ rotl(x, 9) ^ rotl(x, 17);
  endfunction
  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rotl(x, 15) ^ rotl(x, 23);
  endfunction
endpackage

// File: rtl/sm3_stream_hash_if.sv
// sm3_stream_hash_if: block-stream / job-control bundle between a hash client and the SM3 engine
// master: client side (drives start, num_blocks, blk_data, blk_valid[, iv_in, iv_sel])
// slave : engine side (drives blk_ready, hash_value, done, busy, blk_idx, err)
// Optional macro SM3_IV_LOAD_EN adds iv_in/iv_sel for continuing a hash across jobs.
interface sm3_stream_hash_if
  import sm3_stream_hash_pkg::*;
#(parameter int CNT_W = 8);
  logic                  start;
  logic [CNT_W-1:0]      num_blocks;
  logic [SM3_BLK_W-1:0]  blk_data;
  logic                  blk_valid;
  logic                  blk_ready;
  logic [SM3_HASH_W-1:0] hash_value;
  logic                  done;
  logic                  busy;
  logic [CNT_W-1:0]      blk_idx;
  logic                  err;
`ifdef SM3_IV_LOAD_EN
  logic [SM3_HASH_W-1:0] iv_in;
  logic                  iv_sel;
`endif
  modport master (
`ifdef SM3_IV_LOAD_EN
    output iv_in, iv_sel,
`endif
    output start, num_blocks, blk_data, blk_valid,
    input  blk_ready, hash_value, done, busy, blk_idx, err
  );
  modport slave (
`ifdef SM3_IV_LOAD_EN
    input  iv_in, iv_sel,
`endif
    input  start, num_blocks, blk_data, blk_valid,
    output blk_ready, hash_value, done, busy, blk_idx, err
  );
endinterface

// File: rtl/sm3_CF.sv
// sm3_CF: iterative SM3 compression function, one round per clock (64 rounds)
// Ports: clk, reset (async active-low), cf_start (level, held until cf_end),
//        cf_v (chaining value in), cf_blk (512-bit block), cf_end (1-cycle pulse),
//        cf_hash (V xor final ABCDEFGH, valid with cf_end and held afterwards).
module sm3_CF
  import sm3_stream_hash_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cf_start,
  input  logic [SM3_HASH_W-1:0] cf_v,
  input  logic [SM3_BLK_W-1:0]  cf_blk,
  output logic                  cf_end,
  output logic [SM3_HASH_W-1:0] cf_hash
);
  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] w [16];
  logic [SM3_HASH_W-1:0] v;
  logic [5:0] j;
  logic run, hold;
  logic [31:0] tj, ff, gg, ss1, ss2, tt1, tt2, w_new;
  // w[] is a sliding window holding W[j..j+15]; W'[j] = W[j] ^ W[j+4].
  always_comb begin
    tj = j < 6'd16 ? 32'h79cc4519 : 32'h7a879d8a;
    ff = j < 6'd16 ? a ^ b ^ c : (a & b) | (a & c) | (b & c);
    gg = j < 6'd16 ? e ^ f ^ g : (e & f) | (~e & g);
    ss1 = rotl(rotl(a, 12) + e + rotl(tj, int'(j[4:0])), 7);
    ss2 = ss1 ^ rotl(a, 12);
    tt1 = ff + d + ss2 + (w[0] ^ w[4]);
    tt2 = gg + h + ss1 + w[0];
    w_new = p1(w[0] ^ w[7] ^ rotl(w[13], 15)) ^ rotl(w[3], 7) ^ w[10];
  end
  // hold blocks a restart while the controller still has cf_start high after cf_end.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      {a, b, c, d, e, f, g, h} <= '0;
      for (int i = 0; i < 16; i++) w[i] <= '0;
      v <= '0;
      j <= '0;
      run <= 1'b0;
      hold <= 1'b0;
      cf_end <= 1'b0;
      cf_hash <= '0;
    end else begin
      cf_end <= 1'b0;
      if (run) begin
        {a, b, c, d} <= {tt1, a, rotl(b, 9), c};
        {e, f, g, h} <= {p0(tt2), e, rotl(f, 19), g};
        for (int i = 0; i < 15; i++) w[i] <= w[i+1];
        w[15] <= w_new;
        j <= j + 6'd1;
        if (j == 6'd63) begin
          run <= 1'b0;
          hold <= 1'b1;
          cf_end <= 1'b1;
          cf_hash <= v ^ {tt1, a, rotl(b, 9), c, p0(tt2), e, rotl(f, 19), g};
        end
      end else if (cf_start && !hold) begin
        {a, b, c, d, e, f, g, h} <= cf_v;
        v <= cf_v;
        for (int i = 0; i < 16; i++) w[i] <= cf_blk[SM3_BLK_W-1-32*i -: 32];
        j <= '0;
        run <= 1'b1;
      end else if (!cf_start) hold <= 1'b0;
    end
endmodule

// File: rtl/sm3_stream_hash.sv
// sm3_stream_hash: multi-block SM3 engine chaining sm3_CF results over a valid/ready block stream
// Ports: clk, reset (async active-low), s (sm3_stream_hash_if.slave: start/num_blocks job control,
//        blk_data/blk_valid/blk_ready block stream, hash_value/done/busy/blk_idx/err status).
// Optional macro SM3_IV_LOAD_EN: iv_sel=1 on start loads iv_in instead of the IV parameter.
module sm3_stream_hash
  import sm3_stream_hash_pkg::*;
#(
  parameter int                    CNT_W = 8,
  parameter logic [SM3_HASH_W-1:0] IV    = SM3_IV
)(
  input logic               clk,
  input logic               reset,
  sm3_stream_hash_if.slave  s
);
  state_t                state;
  logic [CNT_W-1:0]      n_lat, idx_nxt;
  logic [SM3_HASH_W-1:0] v, v_init, cf_hash;
  logic [SM3_BLK_W-1:0]  blk;
  logic                  cf_start, cf_end;
`ifdef SM3_IV_LOAD_EN
  assign v_init = s.iv_sel ? s.iv_in : IV;
`else
  assign v_init = IV;
`endif
  assign idx_nxt = s.blk_idx + CNT_W'(1);
  sm3_CF u_cf (
    .clk     (clk),
    .reset   (reset),
    .cf_start(cf_start),
    .cf_v    (v),
    .cf_blk  (blk),
    .cf_end  (cf_end),
    .cf_hash (cf_hash)
  );
  // start is refused while done is high so a held start cannot fire in the done cycle.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      n_lat <= '0;
      v <= '0;
      blk <= '0;
      cf_start <= 1'b0;
      s.blk_ready <= 1'b0;
      s.hash_value <= '0;
      s.done <= 1'b0;
      s.busy <= 1'b0;
      s.blk_idx <= '0;
      s.err <= 1'b0;
    end else begin
      s.done <= 1'b0;
      case (state)
        IDLE: if (s.start && !s.done) begin
          n_lat <= s.num_blocks;
          v <= v_init;
          s.blk_idx <= '0;
          s.busy <= 1'b1;
          s.err <= s.num_blocks == '0;
          s.blk_ready <= s.num_blocks != '0;
          state <= s.num_blocks == '0 ? FINISH : WAIT_BLK;
        end
        WAIT_BLK: if (s.blk_valid && s.blk_ready) begin
          blk <= s.blk_data;
          cf_start <= 1'b1;
          s.blk_ready <= 1'b0;
          state <= COMPRESS;
        end
        COMPRESS: if (cf_end) begin
          cf_start <= 1'b0;
          v <= cf_hash;
          s.blk_idx <= idx_nxt;
          s.blk_ready <= idx_nxt != n_lat;
          state <= idx_nxt == n_lat ? FINISH : WAIT_BLK;
        end
        FINISH: begin
          s.hash_value <= v;
          s.done <= 1'b1;
          s.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
